// File: rtl/bh1750_sampler.sv
// Dual BH1750 sequencer: powers both sensors up, sets continuous H-res mode and
// periodically reads both over a shared IIC driver, publishing raw and lux values.
module bh1750_sampler #(
  parameter int          CYC_PER_MS  = 100_000,
  parameter logic [6:0]  DEV_ADDR    = 7'h23,
  parameter logic [7:0]  CMD_PWR_ON  = 8'h01,
  parameter logic [7:0]  MODE_CMD    = 8'h10,
  parameter int          PWRUP_MS    = 10,
  parameter int          MEAS_MS     = 180,
  parameter int          ACK_CYC     = 16,
  parameter int          TIMEOUT_CYC = 2_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic [6:0]  iic_addr,
  output logic [7:0]  iic_data,
  output logic        iic_write,
  output logic        iic_read,
  input  logic        iic_busy,
  input  logic [7:0]  rd_h1,
  input  logic [7:0]  rd_l1,
  input  logic [7:0]  rd_h2,
  input  logic [7:0]  rd_l2,
  output logic [15:0] raw1,
  output logic [15:0] raw2,
  output logic [15:0] lux1,
  output logic [15:0] lux2,
  output logic        sample_valid,
  output logic        timeout_err,
  output logic [3:0]  dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE, S_PWRUP, S_PWR, S_MODE, S_MEAS, S_RD, S_LATCH, S_LUX, S_ERR
  } state_t;

  // Driver handshake: data settles one cycle before the request rises; the request
  // is a level held until busy is seen high, and the transfer ends on busy low.
  typedef enum logic [1:0] {PH_DATA, PH_SET, PH_REQ, PH_BUSY} phase_t;

  state_t      state, state_d;
  phase_t      phase, phase_d;
  logic [31:0] pre_cnt, ms_cnt, hs_cnt;
  logic        req_on, req_off, fault, do_latch, do_lux;
  logic        is_read;
  logic [7:0]  cmd;
  logic [23:0] prod1, prod2;

  assign iic_addr  = DEV_ADDR;
  assign dbg_state = state;
  assign is_read   = (state == S_RD);
  assign cmd       = (state == S_MODE) ? MODE_CMD : CMD_PWR_ON;
  assign prod1     = 24'(raw1) * 24'd205;
  assign prod2     = 24'(raw2) * 24'd205;

  always_comb begin
    state_d  = state;
    phase_d  = phase;
    req_on   = 1'b0;
    req_off  = 1'b0;
    fault    = 1'b0;
    do_latch = 1'b0;
    do_lux   = 1'b0;
    case (state)
      S_IDLE:  if (enable) state_d = S_PWRUP;
      S_PWRUP: begin
        if (!enable)                       state_d = S_IDLE;
        else if (ms_cnt == 32'(PWRUP_MS))  state_d = S_PWR;
      end
      S_PWR, S_MODE, S_RD: begin
        case (phase)
          PH_DATA: phase_d = PH_SET;
          PH_SET: if (!iic_busy) begin
            req_on  = 1'b1;
            phase_d = PH_REQ;
          end
          PH_REQ: begin
            if (iic_busy) begin
              req_off = 1'b1;
              phase_d = PH_BUSY;
            end else if (hs_cnt == 32'(ACK_CYC - 1)) begin
              fault = 1'b1;
            end
          end
          default: begin
            if (!iic_busy) begin
              phase_d = PH_DATA;
              state_d = (state == S_PWR) ? S_MODE : (state == S_MODE) ? S_MEAS : S_LATCH;
            end else if (hs_cnt == 32'(TIMEOUT_CYC - 1)) begin
              fault = 1'b1;
            end
          end
        endcase
        if (fault) begin
          req_off = 1'b1;
          phase_d = PH_DATA;
          state_d = S_ERR;
        end
      end
      S_MEAS: begin
        if (!enable)                     state_d = S_IDLE;
        else if (ms_cnt == 32'(MEAS_MS)) state_d = S_RD;
      end
      S_LATCH: begin
        do_latch = 1'b1;
        state_d  = S_LUX;
      end
      S_LUX: begin
        do_lux  = 1'b1;
        state_d = enable ? S_MEAS : S_IDLE;
      end
      S_ERR: begin
        if (!enable)              state_d = S_IDLE;
        else if (ms_cnt == 32'd1) state_d = S_PWRUP;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d != state) phase_d = PH_DATA;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      phase   <= PH_DATA;
      pre_cnt <= '0;
      ms_cnt  <= '0;
      hs_cnt  <= '0;
    end else begin
      state <= state_d;
      phase <= phase_d;
      // Millisecond timebase restarts on every state change.
      if (state_d != state) begin
        pre_cnt <= '0;
        ms_cnt  <= '0;
      end else if (pre_cnt == 32'(CYC_PER_MS - 1)) begin
        pre_cnt <= '0;
        ms_cnt  <= ms_cnt + 32'd1;
      end else begin
        pre_cnt <= pre_cnt + 32'd1;
      end
      if (state_d != state || phase_d != phase) hs_cnt <= '0;
      else                                      hs_cnt <= hs_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iic_write    <= 1'b0;
      iic_read     <= 1'b0;
      iic_data     <= '0;
      raw1         <= '0;
      raw2         <= '0;
      lux1         <= '0;
      lux2         <= '0;
      sample_valid <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      if (req_on) begin
        iic_write <= !is_read;
        iic_read  <= is_read;
      end else if (req_off) begin
        iic_write <= 1'b0;
        iic_read  <= 1'b0;
      end
      if ((state == S_PWR || state == S_MODE) && phase == PH_DATA) iic_data <= cmd;
      if (do_latch) begin
        raw1 <= {rd_h1, rd_l1};
        raw2 <= {rd_h2, rd_l2};
      end
      if (do_lux) begin
        lux1 <= prod1[23:8];
        lux2 <= prod2[23:8];
      end
      sample_valid <= do_lux;
      if (!enable)    timeout_err <= 1'b0;
      else if (fault) timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bh1750_sampler.sv
// Bench for bh1750_sampler with scaled timing: a negedge bus model of the IIC driver,
// a sample model fed from the bytes the bus model serves, and directed scenarios.
module tb_bh1750_sampler;
  localparam int CYC       = 20;
  localparam int PWRUP_MS  = 10;
  localparam int MEAS_MS   = 18;
  localparam int ACK       = 16;
  localparam int TMO       = 200;
  localparam int BUSY_LEN  = 6;
  localparam int STUCK_LEN = 250;

  logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b0, iic_busy = 1'b0;
  logic [7:0]  rd_h1 = '0, rd_l1 = '0, rd_h2 = '0, rd_l2 = '0;
  logic [6:0]  iic_addr;
  logic [7:0]  iic_data;
  logic        iic_write, iic_read, sample_valid, timeout_err;
  logic [15:0] raw1, raw2, lux1, lux2;
  logic [3:0]  dbg_state;

  bh1750_sampler #(
    .CYC_PER_MS(CYC), .DEV_ADDR(7'h23), .CMD_PWR_ON(8'h01), .MODE_CMD(8'h10),
    .PWRUP_MS(PWRUP_MS), .MEAS_MS(MEAS_MS), .ACK_CYC(ACK), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .iic_addr(iic_addr), .iic_data(iic_data),
    .iic_write(iic_write), .iic_read(iic_read), .iic_busy(iic_busy),
    .rd_h1(rd_h1), .rd_l1(rd_l1), .rd_h2(rd_h2), .rd_l2(rd_l2),
    .raw1(raw1), .raw2(raw2), .lux1(lux1), .lux2(lux2),
    .sample_valid(sample_valid), .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int vectors = 0, miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    vectors++;
    if (act < lo || act > hi) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // sample model
  logic [63:0] exp_q[$];
  logic [31:0] rd_tab[$];
  logic [7:0]  wr_log[$];

  function automatic logic [15:0] lux_of(input logic [15:0] r);
    int unsigned p;
    p = 32'(r) * 205;
    return 16'(p / 256);
  endfunction

  function automatic logic [63:0] expect_of(input logic [31:0] b);
    return {b[31:16], lux_of(b[31:16]), b[15:0], lux_of(b[15:0])};
  endfunction

  // bus model: 0 normal, 1 never busy, 2 busy stuck
  int mode = 0;
  int req_rises = 0;
  int busy_rise_cyc = 0;
  initial begin
    logic        bm_prev;
    logic        is_rd;
    logic [31:0] b;
    int          len;
    bm_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && (iic_write || iic_read) && !bm_prev) begin
        req_rises++;
        is_rd = iic_read;
        if (iic_write) wr_log.push_back(iic_data);
        if (mode != 1) begin
          for (int i = 0; i < 2 && rst_n; i++) @(negedge clk);
          if (rst_n) begin
            if (is_rd) begin
              b = (rd_tab.size() > 0) ? rd_tab.pop_front() : 32'h0;
              {rd_h1, rd_l1, rd_h2, rd_l2} = b;
              exp_q.push_back(expect_of(b));
            end
            iic_busy = 1'b1;
            busy_rise_cyc = cyc;
            len = (mode == 2) ? STUCK_LEN : BUSY_LEN;
            for (int i = 0; i < len && rst_n; i++) @(negedge clk);
          end
          iic_busy = 1'b0;
        end
      end
      bm_prev = iic_write || iic_read;
    end
  end

  // scoreboard / per-cycle compare
  int valid_cnt = 0;
  initial begin
    logic [63:0] cur;
    logic        p_req, p_busy, p_en, rise;
    cur = '0; p_req = 1'b0; p_busy = 1'b0; p_en = 1'b0;
    forever begin
      @(negedge clk);
      check("rw_exclusive", {63'd0, iic_write & iic_read}, 64'd0);
      rise = (iic_write || iic_read) && !p_req;
      if (rise) check("rise_while_busy", {63'd0, p_busy}, 64'd0);
      if (!rst_n) begin
        exp_q.delete();
        cur = '0;
        check("reset_outputs", {iic_write, iic_read, iic_data, sample_valid, timeout_err}, 64'd0);
      end else if (!p_en) begin
        check("err_cleared_by_enable", {63'd0, timeout_err}, 64'd0);
      end
      if (sample_valid) begin
        valid_cnt++;
        if (exp_q.size() == 0) check("valid_without_read", 64'(exp_q.size()), 64'd1);
        else begin
          cur = exp_q.pop_front();
          check("sample", {raw1, lux1, raw2, lux2}, cur);
        end
      end
      check("lux_hold", {lux1, lux2}, {cur[47:32], cur[15:0]});
      if (exp_q.size() == 0) check("raw_hold", {raw1, raw2}, {cur[63:48], cur[31:16]});
      p_req  = iic_write || iic_read;
      p_busy = iic_busy;
      p_en   = enable;
    end
  end

  // driver tasks
  task automatic wait_valid(input string name, input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sample_valid && n < budget);
    check(name, {63'd0, sample_valid}, 64'd1);
  endtask

  task automatic wait_req(input string name, input bit rd, input int budget, output int n);
    logic p, c;
    bit seen;
    seen = 0;
    n = 0;
    p = rd ? iic_read : iic_write;
    do begin
      @(negedge clk);
      n++;
      c = rd ? iic_read : iic_write;
      if (c && !p) seen = 1;
      p = c;
    end while (!seen && n < budget);
    check(name, {63'd0, seen}, 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n, hi, r0, vc0;
    // 1: reset with enable high, first sample
    enable = 1'b1;
    rd_tab.push_back(32'h1234_0078);
    repeat (3) @(negedge clk);
    check("reset_state", dbg_state, 64'd0);
    check("addr", iic_addr, 64'h23);
    check("reset_raw_lux", {raw1, raw2, lux1, lux2}, 64'd0);
    rst_n = 1'b1;
    wait_valid("t1_valid_seen", 1500, n);
    check("t1_raw1", raw1, 64'h1234);
    check("t1_lux1", lux1, 64'h0E93);
    check("t1_raw2", raw2, 64'h0078);
    check("t1_lux2", lux2, 64'h0060);
    check("t1_write_count", 64'(wr_log.size()), 64'd2);
    check("t1_write0", wr_log[0], 64'h01);
    check("t1_write1", wr_log[1], 64'h10);
    check("t1_valid_count", valid_cnt, 64'd1);
    @(negedge clk);
    check("t1_pulse_width", {63'd0, sample_valid}, 64'd0);

    // 2: continuous sampling period, max-value arithmetic
    rd_tab.push_back(32'hFFFF_0001);
    rd_tab.push_back(32'h8000_ABCD);
    wait_valid("t2_valid_a", MEAS_MS * CYC + 200, n);
    check_range("t2_interval_a", n + 1, MEAS_MS * CYC, MEAS_MS * CYC + CYC);
    check("t2_lux1_max", {raw1, lux1}, 64'hFFFF_CCFF);
    check("t2_lux2_one", {raw2, lux2}, 64'h0001_0000);
    @(negedge clk);
    wait_valid("t2_valid_b", MEAS_MS * CYC + 200, n);
    check_range("t2_interval_b", n + 1, MEAS_MS * CYC, MEAS_MS * CYC + CYC);
    check("t2_lux_b", {lux1, lux2}, 64'h6680_8993);
    @(negedge clk);

    // 5: enable drops during a read
    rd_tab.push_back(32'h0100_0005);
    wait_req("t5_read_seen", 1'b1, MEAS_MS * CYC + 200, n);
    enable = 1'b0;
    wait_valid("t5_valid_seen", 60, n);
    check("t5_lux", {lux1, lux2}, 64'h00CD_0004);
    r0 = req_rises;
    repeat (MEAS_MS * CYC + 100) @(negedge clk);
    check("t5_no_requests", req_rises - r0, 64'd0);
    check("t5_err_clear", {63'd0, timeout_err}, 64'd0);
    check("t5_idle", dbg_state, 64'd0);

    // 3: driver never acknowledges
    mode = 1;
    enable = 1'b1;
    wait_req("t3_write_seen", 1'b0, PWRUP_MS * CYC + 50, n);
    hi = 0;
    while (iic_write && hi < 100) begin
      @(negedge clk);
      hi++;
    end
    check("t3_req_hold", hi, ACK);
    check("t3_err_set", {63'd0, timeout_err}, 64'd1);
    wait_req("t3_rewrite_seen", 1'b0, 12 * CYC + 50, n);
    check_range("t3_reinit_delay", n, 11 * CYC, 11 * CYC + 6);
    enable = 1'b0;
    repeat (40) @(negedge clk);
    check("t3_err_cleared", {63'd0, timeout_err}, 64'd0);
    check("t3_idle", dbg_state, 64'd0);

    // 4: busy stuck high
    mode = 2;
    vc0 = valid_cnt;
    enable = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!iic_busy && n < PWRUP_MS * CYC + 50);
    check("t4_busy_seen", {63'd0, iic_busy}, 64'd1);
    n = 0;
    while (!timeout_err && n < TMO + 50) begin
      @(negedge clk);
      n++;
    end
    check("t4_err_latency", cyc - busy_rise_cyc, TMO + 1);
    check("t4_no_valid", valid_cnt, vc0);
    enable = 1'b0;
    n = 0;
    while (iic_busy && n < STUCK_LEN + 50) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    check("t4_err_cleared", {63'd0, timeout_err}, 64'd0);

    // 6: reset mid-write, restart from power-up delay
    mode = 0;
    enable = 1'b1;
    wait_req("t6_write_seen", 1'b0, PWRUP_MS * CYC + 50, n);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("t6_reset_outputs", {raw1, raw2, lux1, lux2}, 64'd0);
    check("t6_reset_state", dbg_state, 64'd0);
    rst_n = 1'b1;
    wait_req("t6_restart_write", 1'b0, PWRUP_MS * CYC + 50, n);
    check_range("t6_restart_delay", n, PWRUP_MS * CYC + 2, PWRUP_MS * CYC + 6);
    rd_tab.push_back(32'h0F0F_F0F0);
    wait_valid("t6_valid_seen", MEAS_MS * CYC + 300, n);
    check("t6_last_writes", {wr_log[wr_log.size() - 2], wr_log[wr_log.size() - 1]}, 64'h0110);
    check("t6_sample", {raw1, lux1, raw2, lux2}, 64'h0F0F_0C0F_F0F0_C0F0);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
